// File: rtl/matrix_decompiler_pkg.sv
// Shared definitions for the RMII matrix frame path (transmit and receive sides).
// Frame: 01 preamble dibits, 11 SFD, header bytes R and C, then row-major elements.
package matrix_decompiler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    HDR_R   = 3'd2,
    HDR_C   = 3'd3,
    PAYLOAD = 3'd4,
    DRAIN   = 3'd5
  } rx_state_t;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;
  localparam int         HDR_BITS       = 8;
  localparam int         HDR_DIBITS     = HDR_BITS / 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_decompiler_dibit_deserializer.sv
// Assembles LSB-first dibits into a word; the first dibit lands in bits[1:0].
// word/word_done are combinational and include the dibit sampled on this edge.
module dibit_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                         eth_refclk,
  input  logic                         rst_n,
  input  logic                         shift_en,
  input  logic                         clear,
  input  logic [1:0]                   din,
  input  logic [$clog2(WIDTH/2):0]     target,
  output logic [WIDTH-1:0]             word,
  output logic                         word_done
);

  localparam int CW = $clog2(WIDTH/2) + 1;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // Slot-indexed write keeps short words (headers) aligned at bit 0 in a wide register.
  always_comb begin
    word = shreg;
    for (int i = 0; i < WIDTH/2; i++) begin
      if (cnt == CW'(i)) word[2*i +: 2] = din;
    end
  end

  assign word_done = shift_en && (cnt == target - 1'b1);

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= word;
      cnt   <= word_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_decompiler.sv
// RMII receiver that rebuilds a matrix frame as (row, col, element) write strobes.
// Output handshake: valid_data_out is a 1-cycle strobe with no ready; the sink must accept every strobe.
module matrix_decompiler
  import matrix_decompiler_pkg::*;
#(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_SIZE_A       = 32,
  parameter int MAX_SIZE_B       = 32,
  parameter int MIN_PREAMBLE     = 4
) (
  input  logic                          eth_refclk,
  input  logic                          rst_n,
  input  logic                          crsdv,
  input  logic [1:0]                    rxd,
  output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
  output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
  output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
  output logic                          valid_data_out,
  output logic [$clog2(MAX_SIZE_A)-1:0] num_rows,
  output logic [$clog2(MAX_SIZE_B)-1:0] num_cols,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(MAX_SIZE_A);
  localparam int BW = $clog2(MAX_SIZE_B);
  localparam int DW = max_int(HDR_BITS, MAX_ELEMENT_SIZE);
  localparam int TW = $clog2(DW/2) + 1;
  localparam int PW = $clog2(MIN_PREAMBLE) + 1;
  localparam logic [TW-1:0] HDR_TGT  = TW'(HDR_DIBITS);
  localparam logic [TW-1:0] ELEM_TGT = TW'(MAX_ELEMENT_SIZE/2);

  rx_state_t     state, next_state;
  logic [PW-1:0] pre_cnt;
  logic [AW-1:0] r_pend, row;
  logic [BW-1:0] col;
  logic [DW-1:0] word;
  logic          word_done, shift_en, clear, active;
  logic [TW-1:0] target;
  logic          over_a, over_b, last_elem, pre_ok;
  logic          elem_set, done_set, err_set;

  assign state_dbg = state;
  assign active    = (state == HDR_R) || (state == HDR_C) || (state == PAYLOAD);
  assign over_a    = {1'b0, word[HDR_BITS-1:0]} >= 9'(MAX_SIZE_A);
  assign over_b    = {1'b0, word[HDR_BITS-1:0]} >= 9'(MAX_SIZE_B);
  assign last_elem = (row == num_rows) && (col == num_cols);
  assign pre_ok    = pre_cnt >= PW'(MIN_PREAMBLE);

  dibit_deserializer #(.WIDTH(DW)) u_deser (
    .eth_refclk (eth_refclk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .clear      (clear),
    .din        (rxd),
    .target     (target),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (crsdv && rxd == PREAMBLE_DIBIT) next_state = PRE;
      PRE: begin
        if (!crsdv)                           next_state = IDLE;
        else if (rxd == SFD_DIBIT && pre_ok)  next_state = HDR_R;
        else if (rxd != PREAMBLE_DIBIT)       next_state = DRAIN;
      end
      HDR_R: begin
        if (!crsdv)         next_state = IDLE;
        else if (word_done) next_state = over_a ? DRAIN : HDR_C;
      end
      HDR_C: begin
        if (!crsdv)         next_state = IDLE;
        else if (word_done) next_state = over_b ? DRAIN : PAYLOAD;
      end
      PAYLOAD: begin
        if (!crsdv)                       next_state = IDLE;
        else if (word_done && last_elem)  next_state = DRAIN;
      end
      DRAIN:   if (!crsdv) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_en = crsdv && active;
    clear    = !active;
    target   = (state == PAYLOAD) ? ELEM_TGT : HDR_TGT;
    elem_set = (state == PAYLOAD) && word_done;
    done_set = elem_set && last_elem;
    err_set  = (active && !crsdv)
            || ((state == HDR_R) && word_done && over_a)
            || ((state == HDR_C) && word_done && over_b);
  end

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt        <= '0;
      r_pend         <= '0;
      row            <= '0;
      col            <= '0;
      row_addr       <= '0;
      col_addr       <= '0;
      matrix_element <= '0;
      valid_data_out <= 1'b0;
      num_rows       <= '0;
      num_cols       <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      valid_data_out <= elem_set;
      frame_done     <= done_set;
      frame_err      <= err_set;
      if (state == IDLE && next_state == PRE) pre_cnt <= PW'(1);
      else if (state == PRE && crsdv && rxd == PREAMBLE_DIBIT && pre_cnt != '1)
        pre_cnt <= pre_cnt + 1'b1;
      if (state == HDR_R && word_done && !over_a) r_pend <= word[AW-1:0];
      // Geometry is committed only once both header bytes are known to be legal.
      if (state == HDR_C && word_done && !over_b) begin
        num_rows <= r_pend;
        num_cols <= word[BW-1:0];
        row      <= '0;
        col      <= '0;
      end
      if (elem_set) begin
        row_addr       <= row;
        col_addr       <= col;
        matrix_element <= word[MAX_ELEMENT_SIZE-1:0];
        if (col == num_cols) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_decompiler.sv
// Directed bench for matrix_decompiler: dibit driver, expected-strobe scoreboard, pulse counters.
module tb_matrix_decompiler;
  import matrix_decompiler_pkg::*;

  logic       eth_refclk = 1'b0;
  logic       rst_n;
  logic       crsdv;
  logic [1:0] rxd;
  logic [4:0] row_addr, col_addr, num_rows, num_cols;
  logic [7:0] matrix_element;
  logic       valid_data_out, frame_done, frame_err;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt, done_cnt, err_cnt;

  logic [17:0] exp_q[$];
  logic [1:0]  dq[$];

  matrix_decompiler dut (
    .eth_refclk     (eth_refclk),
    .rst_n          (rst_n),
    .crsdv          (crsdv),
    .rxd            (rxd),
    .row_addr       (row_addr),
    .col_addr       (col_addr),
    .matrix_element (matrix_element),
    .valid_data_out (valid_data_out),
    .num_rows       (num_rows),
    .num_cols       (num_cols),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .state_dbg      (state_dbg)
  );

  // Clock / reset
  always #10 eth_refclk = ~eth_refclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge eth_refclk);
      crsdv = 1'b0;
      rxd   = 2'b00;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) dq.push_back(b[2*i +: 2]);
  endtask

  task automatic push_hdr(input int pre_n, input logic [7:0] r, input logic [7:0] c);
    for (int i = 0; i < pre_n; i++) dq.push_back(2'b01);
    dq.push_back(2'b11);
    push_byte(r);
    push_byte(c);
  endtask

  task automatic expect_elem(input logic [4:0] r, input logic [4:0] c, input logic [7:0] e);
    exp_q.push_back({r, c, e});
  endtask

  // Drives up to 'limit' queued dibits with carrier held high, then empties the queue.
  task automatic drive(input int limit);
    int n = 0;
    while (dq.size() > 0 && n < limit) begin
      @(negedge eth_refclk);
      crsdv = 1'b1;
      rxd   = dq.pop_front();
      n++;
    end
    dq.delete();
  endtask

  task automatic start_test();
    @(posedge eth_refclk);
    strobe_cnt = 0;
    done_cnt   = 0;
    err_cnt    = 0;
  endtask

  // Scoreboard
  always @(negedge eth_refclk) begin
    logic [17:0] exp_v;
    if (valid_data_out) begin
      strobe_cnt++;
      check_eq("strobe_queued", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check_eq("strobe_data", {14'd0, row_addr, col_addr, matrix_element}, {14'd0, exp_v});
      end
    end
    if (frame_done) begin
      done_cnt++;
      check_eq("done_on_last", 32'(valid_data_out && exp_q.size() == 0), 1);
    end
    if (frame_err) err_cnt++;
    if (frame_done || frame_err) check_eq("done_err_excl", 32'(frame_done && frame_err), 0);
  end

  task automatic check_counts(input string tag, input int s, input int d, input int e);
    check_eq({tag, "_strobes"}, strobe_cnt, s);
    check_eq({tag, "_done"}, done_cnt, d);
    check_eq({tag, "_err"}, err_cnt, e);
    check_eq({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    crsdv = 1'b0;
    rxd   = 2'b00;
    strobe_cnt = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    repeat (3) @(negedge eth_refclk);
    check_eq("rst_valid", valid_data_out, 0);
    check_eq("rst_addr", {row_addr, col_addr}, 0);
    check_eq("rst_elem", matrix_element, 0);
    check_eq("rst_dims", {num_rows, num_cols}, 0);
    check_eq("rst_pulses", {frame_done, frame_err}, 0);
    check_eq("rst_state", state_dbg, 3'(IDLE));
    rst_n = 1'b1;
    idle(2);

    // 1: 2x2 frame with long preamble
    start_test();
    push_hdr(7, 8'd1, 8'd1);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    expect_elem(0, 0, 8'h11); expect_elem(0, 1, 8'h22);
    expect_elem(1, 0, 8'h33); expect_elem(1, 1, 8'h44);
    drive(1000);
    idle(4);
    check_counts("t1", 4, 1, 0);
    check_eq("t1_dims", {num_rows, num_cols}, {5'd1, 5'd1});

    // 2: 1x1 frame, trailing dibits ignored in DRAIN
    start_test();
    push_hdr(5, 8'd0, 8'd0);
    push_byte(8'hA5);
    for (int i = 0; i < 20; i++) dq.push_back(2'($urandom_range(0, 3)));
    expect_elem(0, 0, 8'hA5);
    drive(1000);
    @(negedge eth_refclk);
    check_eq("t2_drain", state_dbg, 3'(DRAIN));
    idle(4);
    check_counts("t2", 1, 1, 0);
    check_eq("t2_dims", {num_rows, num_cols}, 0);
    check_eq("t2_idle", state_dbg, 3'(IDLE));

    // 3: carrier dropped mid third element, then a good 1x2 frame
    start_test();
    push_hdr(7, 8'd1, 8'd1);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    expect_elem(0, 0, 8'h01); expect_elem(0, 1, 8'h02);
    drive(8 + 8 + 8 + 2);
    idle(4);
    check_counts("t3a", 2, 0, 1);
    check_eq("t3a_idle", state_dbg, 3'(IDLE));
    start_test();
    push_hdr(4, 8'd0, 8'd1);
    push_byte(8'h5A); push_byte(8'hC3);
    expect_elem(0, 0, 8'h5A); expect_elem(0, 1, 8'hC3);
    drive(1000);
    idle(4);
    check_counts("t3b", 2, 1, 0);
    check_eq("t3b_dims", {num_rows, num_cols}, {5'd0, 5'd1});

    // 4: illegal R, then illegal C; geometry must stay at the previous frame's values
    start_test();
    push_hdr(6, 8'd32, 8'd0);
    push_byte(8'h77); push_byte(8'h88);
    drive(1000);
    @(negedge eth_refclk);
    check_eq("t4a_drain", state_dbg, 3'(DRAIN));
    idle(4);
    check_counts("t4a", 0, 0, 1);
    start_test();
    push_hdr(6, 8'd3, 8'd40);
    push_byte(8'h99);
    drive(1000);
    idle(4);
    check_counts("t4b", 0, 0, 1);
    check_eq("t4_dims_held", {num_rows, num_cols}, {5'd0, 5'd1});

    // 5: short preamble is dropped silently; next frame still decodes
    start_test();
    push_hdr(2, 8'd0, 8'd0);
    push_byte(8'h12);
    drive(1000);
    @(negedge eth_refclk);
    check_eq("t5_drain", state_dbg, 3'(DRAIN));
    idle(1);
    check_counts("t5a", 0, 0, 0);
    start_test();
    push_hdr(4, 8'd1, 8'd0);
    push_byte(8'h7E); push_byte(8'h81);
    expect_elem(0, 0, 8'h7E); expect_elem(1, 0, 8'h81);
    drive(1000);
    idle(4);
    check_counts("t5b", 2, 1, 0);
    check_eq("t5b_dims", {num_rows, num_cols}, {5'd1, 5'd0});

    // 6: asynchronous reset mid payload
    start_test();
    push_hdr(7, 8'd1, 8'd1);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    expect_elem(0, 0, 8'hAA); expect_elem(0, 1, 8'hBB);
    drive(8 + 8 + 8 + 2);
    #5;
    rst_n = 1'b0;
    crsdv = 1'b0;
    #1;
    check_eq("t6_rst_addr", {row_addr, col_addr}, 0);
    check_eq("t6_rst_elem", matrix_element, 0);
    check_eq("t6_rst_dims", {num_rows, num_cols}, 0);
    check_eq("t6_rst_flags", {valid_data_out, frame_done, frame_err}, 0);
    check_eq("t6_rst_state", state_dbg, 3'(IDLE));
    repeat (2) @(negedge eth_refclk);
    #5 rst_n = 1'b1;
    idle(2);
    check_counts("t6a", 2, 0, 0);
    start_test();
    push_hdr(4, 8'd0, 8'd0);
    push_byte(8'h3C);
    expect_elem(0, 0, 8'h3C);
    drive(1000);
    idle(4);
    check_counts("t6b", 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
